key_search: RTL and testbench
=============================

KEY_SEARCH -- requirements
Module: key_search

Interface
REQ-001 Parameters SHALL be (name, default, meaning): KEY_W, 24, key width in bits; KEY_STEP, 1, key increment for partitioned multi-instance search (1..2^KEY_W-1); KEY_LAST, all ones, final key evaluated; CHAR_LO, 8'h20, lowest accepted plaintext byte; CHAR_HI, 8'h7E, highest accepted plaintext byte.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 en  in  1  start request; accepted only while rdy=1.
REQ-005 rdy  out  1  idle/accepting start.
REQ-006 key_base  in  KEY_W  first key to try; latched on accepted en.
REQ-007 stop  in  1  abort request (e.g. peer instance found key).
REQ-008 key  out  KEY_W  found key; valid when key_valid=1.
REQ-009 key_valid, exhausted, aborted  out  1 each  sticky completion status.
REQ-010 keys_tried  out  KEY_W  count of keys fully evaluated, saturating.
REQ-011 ct_addr  out  8 / ct_rddata  in  8  ciphertext memory read port; 1-cycle read latency.
REQ-012 a4_en  out  1 / a4_rdy  in  1 / a4_key  out  KEY_W  decryption engine handshake and key.
REQ-013 pt_sel  out  1  1 = this block owns plaintext memory port, 0 = engine owns it.
REQ-014 pt_addr  out  8 / pt_rddata  in  8  plaintext memory read port; 1-cycle read latency.

Function
REQ-015 States SHALL be IDLE, LEN_RD, LEN_WAIT, KICK, RUN, CHECK, DONE; rdy=1 exactly in IDLE and DONE.
REQ-016 en=1 in IDLE/DONE: cur_key<=key_base, clear key_valid/exhausted/aborted/keys_tried, go LEN_RD; en while busy SHALL be ignored.
REQ-017 LEN_RD drives ct_addr=0; LEN_WAIT latches len<=ct_rddata; len=0 -> DONE with key<=key_base, key_valid=1, no a4_en pulse, keys_tried=1; else -> KICK.
REQ-018 a4_key SHALL equal cur_key from KICK through end of CHECK.
REQ-019 KICK: when a4_rdy=1, assert a4_en for exactly one cycle and go RUN; a4_en SHALL be 0 in every other cycle.
REQ-020 RUN: a4_rdy ignored in its first cycle; thereafter a4_rdy=1 -> CHECK; pt_sel=0 in KICK/RUN, 1 in CHECK.
REQ-021 CHECK SHALL issue pt_addr=1,2,...,len one per cycle and compare each returned byte one cycle later, unsigned, pass iff CHAR_LO<=byte<=CHAR_HI.
REQ-022 First failing byte SHALL end CHECK immediately (remaining reads discarded); all len bytes passing -> DONE, key<=cur_key, key_valid=1.
REQ-023 Each key leaving CHECK (pass or fail) SHALL increment keys_tried by 1, saturating at all ones.
REQ-024 On fail: if cur_key==KEY_LAST or cur_key+KEY_STEP carries out of KEY_W bits -> DONE, exhausted=1; else cur_key<=cur_key+KEY_STEP, -> KICK.
REQ-025 stop=1 in LEN_RD, LEN_WAIT, KICK or CHECK -> DONE next cycle with aborted=1, key_valid=0.
REQ-026 stop=1 in RUN SHALL set a pending flag; block stays in RUN until a4_rdy=1, then -> DONE with aborted=1 (engine never abandoned mid-operation).
REQ-027 Simultaneous stop and final-byte pass in CHECK: found wins (key_valid=1, aborted=0); stop with fail on KEY_LAST: exhausted=1, aborted=0.
REQ-028 Exactly one of key_valid/exhausted/aborted SHALL be 1 in DONE; all three 0 outside DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, rdy=1, key=0, key_valid=0, exhausted=0, aborted=0, keys_tried=0, a4_en=0, a4_key=0, pt_sel=0, ct_addr=0, pt_addr=0, len=0, stop-pending=0.
REQ-030 Reset mid-search SHALL discard all progress; no a4_en pulse until a new accepted en.

Verification
REQ-031 Engine model writes pt[i]=0x41 if key==3 else 0x01; base=0, len=5 -> key=3, key_valid=1, keys_tried=4, 4 a4_en pulses.
REQ-032 len=0, key_base=24'h123456 -> DONE within 3 cycles of en, key=24'h123456, key_valid=1, zero a4_en pulses.
REQ-033 KEY_W=8, base=8'hFC, no valid key -> keys FC..FF tried, exhausted=1, keys_tried=4; KEY_STEP=2, base=1, valid key 4 -> exhausted (odd keys only); valid key 5 -> found.
REQ-034 Byte boundaries: 0x20 and 0x7E pass, 0x1F and 0x7F fail; failing byte at index 2 of len=200 -> next KICK within 4 cycles of that read.
REQ-035 stop pulsed 1 cycle mid-RUN -> a4_en stays 0, DONE only after a4_rdy returns, aborted=1; en during RUN ignored.
REQ-036 rst_n low mid-CHECK -> all outputs at REQ-029 values same cycle; new en after release restarts from new key_base.

Source files
------------

// File: rtl/key_search.sv
// key_search: brute-force key search controller.
// Reads the ciphertext length from ct memory address 0. For each candidate key
// it starts the decryption engine, waits for it to finish, then scans
// plaintext bytes 1..len for printable characters (CHAR_LO..CHAR_HI). The
// first key whose plaintext is entirely printable is reported. Keys advance by
// KEY_STEP so several instances can split the key space between them.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   en, rdy, key_base     start handshake and first key to try
//   stop                  abort request
//   key, key_valid        found key and its valid flag
//   exhausted, aborted    sticky completion status
//   keys_tried            saturating count of fully evaluated keys
//   ct_addr, ct_rddata    ciphertext read port (1-cycle latency)
//   a4_en, a4_rdy, a4_key decryption engine handshake and key
//   pt_sel                1 = this block owns the plaintext port
//   pt_addr, pt_rddata    plaintext read port (1-cycle latency)
module key_search #(
  parameter int unsigned      KEY_W    = 24,
  parameter int unsigned      KEY_STEP = 1,
  parameter logic [KEY_W-1:0] KEY_LAST = '1,
  parameter logic [7:0]       CHAR_LO  = 8'h20,
  parameter logic [7:0]       CHAR_HI  = 8'h7E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key_base,
  input  logic             stop,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             exhausted,
  output logic             aborted,
  output logic [KEY_W-1:0] keys_tried,
  output logic [7:0]       ct_addr,
  input  logic [7:0]       ct_rddata,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [KEY_W-1:0] a4_key,
  output logic             pt_sel,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata
);

  typedef enum logic [2:0] {
    IDLE, LEN_RD, LEN_WAIT, KICK, RUN, CHECK, DONE
  } state_t;

  localparam logic [KEY_W:0] STEP_EXT = (KEY_W+1)'(KEY_STEP);

  state_t           state, state_d;
  logic [KEY_W-1:0] cur_key;
  logic [7:0]       len;
  logic             run_first;
  logic             stop_pend;
  logic             issuing;
  logic             rd_pend;
  logic             rd_last;

  logic             start, len_load, found_base, found_cur;
  logic             exhaust, abort, try_inc, next_key;
  logic [KEY_W:0]   key_sum;
  logic             last_key;
  logic             byte_ok;

  // The extra top bit of the sum is the carry out of the key width.
  assign key_sum  = {1'b0, cur_key} + STEP_EXT;
  assign last_key = (cur_key == KEY_LAST) || key_sum[KEY_W];
  assign byte_ok  = (pt_rddata >= CHAR_LO) && (pt_rddata <= CHAR_HI);

  assign rdy     = (state == IDLE) || (state == DONE);
  assign pt_sel  = (state == CHECK);
  assign ct_addr = 8'd0;
  assign a4_key  = cur_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    start      = 1'b0;
    len_load   = 1'b0;
    found_base = 1'b0;
    found_cur  = 1'b0;
    exhaust    = 1'b0;
    abort      = 1'b0;
    try_inc    = 1'b0;
    next_key   = 1'b0;
    a4_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (en) begin
          start   = 1'b1;
          state_d = LEN_RD;
        end
      end
      LEN_RD: begin
        if (stop) begin
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = LEN_WAIT;
        end
      end
      LEN_WAIT: begin
        if (stop) begin
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          len_load = 1'b1;
          // An empty message is trivially printable: the first key wins.
          if (ct_rddata == 8'd0) begin
            found_base = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = KICK;
          end
        end
      end
      KICK: begin
        if (stop) begin
          abort   = 1'b1;
          state_d = DONE;
        end else if (a4_rdy) begin
          a4_en   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // The engine may still show ready in the cycle after the kick, so
        // a4_rdy is only trusted from the second RUN cycle on. A stop here
        // is deferred until the engine completes.
        if (!run_first && a4_rdy) begin
          if (stop_pend || stop) begin
            abort   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // A pass/fail decision takes priority over a simultaneous stop.
        if (rd_pend && !byte_ok) begin
          try_inc = 1'b1;
          if (last_key) begin
            exhaust = 1'b1;
            state_d = DONE;
          end else if (stop) begin
            abort   = 1'b1;
            state_d = DONE;
          end else begin
            next_key = 1'b1;
            state_d  = KICK;
          end
        end else if (rd_pend && rd_last) begin
          try_inc   = 1'b1;
          found_cur = 1'b1;
          state_d   = DONE;
        end else if (stop) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_key    <= '0;
      len        <= 8'd0;
      key        <= '0;
      key_valid  <= 1'b0;
      exhausted  <= 1'b0;
      aborted    <= 1'b0;
      keys_tried <= '0;
      run_first  <= 1'b0;
      stop_pend  <= 1'b0;
      pt_addr    <= 8'd0;
      issuing    <= 1'b0;
      rd_pend    <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (start) begin
        cur_key    <= key_base;
        key_valid  <= 1'b0;
        exhausted  <= 1'b0;
        aborted    <= 1'b0;
        keys_tried <= '0;
      end
      if (len_load) len <= ct_rddata;
      if (found_base) begin
        key        <= cur_key;
        key_valid  <= 1'b1;
        keys_tried <= KEY_W'(1);
      end
      if (found_cur) begin
        key       <= cur_key;
        key_valid <= 1'b1;
      end
      if (exhaust) exhausted <= 1'b1;
      if (abort)   aborted   <= 1'b1;
      if (try_inc && (keys_tried != '1)) keys_tried <= keys_tried + 1'b1;
      if (next_key) cur_key <= key_sum[KEY_W-1:0];

      run_first <= a4_en;

      if (state != RUN)  stop_pend <= 1'b0;
      else if (stop)     stop_pend <= 1'b1;

      // Plaintext scan pipeline: pt_addr is the read being issued, rd_pend
      // marks that pt_rddata holds the byte issued one cycle earlier and
      // rd_last marks that byte as the final one (index len).
      if (state != CHECK && state_d == CHECK) begin
        pt_addr <= 8'd1;
        issuing <= 1'b1;
        rd_pend <= 1'b0;
        rd_last <= 1'b0;
      end else if (state == CHECK && state_d == CHECK) begin
        rd_pend <= issuing;
        rd_last <= issuing && (pt_addr == len);
        if (issuing) begin
          if (pt_addr == len) issuing <= 1'b0;
          else                pt_addr <= pt_addr + 8'd1;
        end
      end else begin
        pt_addr <= 8'd0;
        issuing <= 1'b0;
        rd_pend <= 1'b0;
        rd_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_search.sv
// tb_key_search: directed bench for key_search.
// Three instances: A (default 24-bit), B (8-bit, step 2), C (8-bit, step 1).
// A shared engine/memory model serves all three: the engine captures a4_key
// on each a4_en pulse, stays busy for eng_lat cycles, and plaintext bytes are
// good_byte for the instance's good key, otherwise 0x41 below bad_idx and
// bad_byte from bad_idx on.
module tb_key_search;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  en     = 3'b000;
  logic [2:0]  stop   = 3'b000;
  logic [2:0]  a4_rdy = 3'b111;
  logic [2:0]  rdy, key_valid, exhausted, aborted, a4_en, pt_sel;
  logic [23:0] key_base [3];
  logic [7:0]  ct_addr_o [3];
  logic [7:0]  ct_rd [3];
  logic [7:0]  pt_addr_o [3];
  logic [7:0]  pt_rd [3];
  logic [23:0] a4key_o [3];

  logic [23:0] key_a, tried_a, a4key_a;
  logic [7:0]  key_b, tried_b, a4key_b;
  logic [7:0]  key_c, tried_c, a4key_c;

  assign a4key_o[0] = a4key_a;
  assign a4key_o[1] = {16'd0, a4key_b};
  assign a4key_o[2] = {16'd0, a4key_c};

  key_search u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key_base(key_base[0]),
    .stop(stop[0]), .key(key_a), .key_valid(key_valid[0]), .exhausted(exhausted[0]),
    .aborted(aborted[0]), .keys_tried(tried_a), .ct_addr(ct_addr_o[0]),
    .ct_rddata(ct_rd[0]), .a4_en(a4_en[0]), .a4_rdy(a4_rdy[0]), .a4_key(a4key_a),
    .pt_sel(pt_sel[0]), .pt_addr(pt_addr_o[0]), .pt_rddata(pt_rd[0])
  );

  key_search #(.KEY_W(8), .KEY_STEP(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key_base(key_base[1][7:0]),
    .stop(stop[1]), .key(key_b), .key_valid(key_valid[1]), .exhausted(exhausted[1]),
    .aborted(aborted[1]), .keys_tried(tried_b), .ct_addr(ct_addr_o[1]),
    .ct_rddata(ct_rd[1]), .a4_en(a4_en[1]), .a4_rdy(a4_rdy[1]), .a4_key(a4key_b),
    .pt_sel(pt_sel[1]), .pt_addr(pt_addr_o[1]), .pt_rddata(pt_rd[1])
  );

  key_search #(.KEY_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key_base(key_base[2][7:0]),
    .stop(stop[2]), .key(key_c), .key_valid(key_valid[2]), .exhausted(exhausted[2]),
    .aborted(aborted[2]), .keys_tried(tried_c), .ct_addr(ct_addr_o[2]),
    .ct_rddata(ct_rd[2]), .a4_en(a4_en[2]), .a4_rdy(a4_rdy[2]), .a4_key(a4key_c),
    .pt_sel(pt_sel[2]), .pt_addr(pt_addr_o[2]), .pt_rddata(pt_rd[2])
  );

  // Engine and memory model
  logic [23:0] good_key [3];
  logic [23:0] eng_key [3] = '{default: 24'd0};
  int          eng_cnt [3] = '{default: 0};
  int          a4_cnt  [3] = '{default: 0};
  int          eng_lat  = 3;
  bit          eng_hold = 1'b0;
  logic [7:0]  ct_len   = 8'd5;
  logic [7:0]  good_byte = 8'h41;
  logic [7:0]  bad_idx   = 8'd1;
  logic [7:0]  bad_byte  = 8'h01;

  function automatic logic [7:0] pt_byte(input int i, input logic [7:0] addr);
    if (eng_key[i] == good_key[i]) return good_byte;
    if (addr < bad_idx) return 8'h41;
    return bad_byte;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pt_rd[i] <= pt_byte(i, pt_addr_o[i]);
      ct_rd[i] <= (ct_addr_o[i] == 8'd0) ? ct_len : 8'hEE;
      if (a4_en[i]) begin
        a4_cnt[i]  <= a4_cnt[i] + 1;
        eng_key[i] <= a4key_o[i];
        eng_cnt[i] <= eng_lat;
        a4_rdy[i]  <= 1'b0;
      end else if (eng_cnt[i] > 0 && !eng_hold) begin
        eng_cnt[i] <= eng_cnt[i] - 1;
        if (eng_cnt[i] == 1) a4_rdy[i] <= 1'b1;
      end
    end
  end

  // Measures cycles from the plaintext read of index 2 to the next a4_en on A
  int cyc      = 0;
  int rd2_cyc  = -1;
  int kick_cyc = -1;
  bit lat_arm  = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!lat_arm) begin
      rd2_cyc  <= -1;
      kick_cyc <= -1;
    end else begin
      if (rd2_cyc < 0 && pt_sel[0] && pt_addr_o[0] == 8'd2) rd2_cyc <= cyc;
      if (rd2_cyc >= 0 && kick_cyc < 0 && a4_en[0]) kick_cyc <= cyc;
    end
  end

  int test_count = 0;
  int fail_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [23:0] base);
    @(negedge clk);
    key_base[i] = base;
    en[i] = 1'b1;
    @(negedge clk);
    en[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, input int budget, output int n);
    n = 0;
    while (!rdy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) checkOutput($sformatf("timeout_dut%0d", i), {31'd0, rdy[i]}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int p0;
    for (int i = 0; i < 3; i++) begin
      key_base[i] = 24'd0;
      good_key[i] = 24'hFFFFFF;
    end

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_rdy",    {29'd0, rdy}, 32'h7);
    checkOutput("rst_key",    key_a, 32'd0);
    checkOutput("rst_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'd0);
    checkOutput("rst_tried",  tried_a, 32'd0);
    checkOutput("rst_a4",     {7'd0, a4_en[0], a4key_a}, 32'd0);
    checkOutput("rst_ports",  {15'd0, pt_sel[0], pt_addr_o[0], ct_addr_o[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Key 3 is the only one giving printable text
    good_key[0] = 24'd3;
    ct_len = 8'd5;
    p0 = a4_cnt[0];
    applyStimulus(0, 24'd0);
    waitDone(0, 400, n);
    checkOutput("find3_key",    key_a, 32'd3);
    checkOutput("find3_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b100);
    checkOutput("find3_tried",  tried_a, 32'd4);
    checkOutput("find3_pulses", a4_cnt[0] - p0, 32'd4);

    // Empty message: first key accepted without using the engine
    good_key[0] = 24'hFFFFFF;
    ct_len = 8'd0;
    p0 = a4_cnt[0];
    applyStimulus(0, 24'h123456);
    waitDone(0, 10, n);
    checkOutput("len0_latency", {31'd0, n <= 2}, 32'd1);
    checkOutput("len0_key",     key_a, 32'h123456);
    checkOutput("len0_status",  {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b100);
    checkOutput("len0_tried",   tried_a, 32'd1);
    checkOutput("len0_pulses",  a4_cnt[0] - p0, 32'd0);

    // 8-bit, step 1: FC..FF all fail
    ct_len = 8'd3;
    p0 = a4_cnt[2];
    applyStimulus(2, 24'hFC);
    waitDone(2, 200, n);
    checkOutput("exh8_status", {29'd0, key_valid[2], exhausted[2], aborted[2]}, 32'b010);
    checkOutput("exh8_tried",  tried_c, 32'd4);
    checkOutput("exh8_pulses", a4_cnt[2] - p0, 32'd4);

    // 8-bit, step 2 from 1: even key 4 never visited
    good_key[1] = 24'd4;
    p0 = a4_cnt[1];
    applyStimulus(1, 24'd1);
    waitDone(1, 3000, n);
    checkOutput("step2_even_status", {29'd0, key_valid[1], exhausted[1], aborted[1]}, 32'b010);
    checkOutput("step2_even_tried",  tried_b, 32'h80);
    checkOutput("step2_even_pulses", a4_cnt[1] - p0, 32'd128);

    // Odd key 5 is reached after 1, 3
    good_key[1] = 24'd5;
    applyStimulus(1, 24'd1);
    waitDone(1, 200, n);
    checkOutput("step2_odd_key",    key_b, 32'd5);
    checkOutput("step2_odd_status", {29'd0, key_valid[1], exhausted[1], aborted[1]}, 32'b100);
    checkOutput("step2_odd_tried",  tried_b, 32'd3);

    // Byte range boundaries
    ct_len = 8'd2;
    good_key[0] = 24'd0;
    good_byte = 8'h20;
    applyStimulus(0, 24'd0);
    waitDone(0, 100, n);
    checkOutput("byte20_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b100);
    checkOutput("byte20_tried",  tried_a, 32'd1);
    good_byte = 8'h7E;
    applyStimulus(0, 24'd0);
    waitDone(0, 100, n);
    checkOutput("byte7e_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b100);
    good_key[2] = 24'hFF;
    good_byte = 8'h1F;
    applyStimulus(2, 24'hFF);
    waitDone(2, 100, n);
    checkOutput("byte1f_status", {29'd0, key_valid[2], exhausted[2], aborted[2]}, 32'b010);
    checkOutput("byte1f_tried",  tried_c, 32'd1);
    good_byte = 8'h7F;
    applyStimulus(2, 24'hFF);
    waitDone(2, 100, n);
    checkOutput("byte7f_status", {29'd0, key_valid[2], exhausted[2], aborted[2]}, 32'b010);
    good_byte = 8'h41;
    applyStimulus(2, 24'hFF);
    waitDone(2, 100, n);
    checkOutput("lastkey_found", {21'd0, key_valid[2], exhausted[2], aborted[2], key_c}, {21'd0, 3'b100, 8'hFF});

    // Early fail at index 2 of a 200-byte message
    ct_len = 8'd200;
    good_key[0] = 24'd1;
    bad_idx = 8'd2;
    lat_arm = 1'b1;
    applyStimulus(0, 24'd0);
    waitDone(0, 600, n);
    checkOutput("early_key",    key_a, 32'd1);
    checkOutput("early_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b100);
    checkOutput("early_tried",  tried_a, 32'd2);
    checkOutput("early_kick_latency",
                {31'd0, (rd2_cyc >= 0) && (kick_cyc > rd2_cyc) && (kick_cyc - rd2_cyc <= 4)}, 32'd1);
    lat_arm = 1'b0;
    bad_idx = 8'd1;

    // Stop during RUN waits for the engine; en while busy ignored
    ct_len = 8'd3;
    good_key[0] = 24'hFFFFFF;
    eng_hold = 1'b1;
    p0 = a4_cnt[0];
    applyStimulus(0, 24'd0);
    n = 0;
    while (a4_cnt[0] == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    stop[0] = 1'b1;
    en[0] = 1'b1;
    key_base[0] = 24'h000777;
    @(negedge clk);
    stop[0] = 1'b0;
    en[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stop_holds_run", {28'd0, rdy[0], key_valid[0], exhausted[0], aborted[0]}, 32'd0);
    eng_hold = 1'b0;
    waitDone(0, 20, n);
    checkOutput("stop_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b001);
    checkOutput("stop_pulses", a4_cnt[0] - p0, 32'd1);
    checkOutput("stop_tried",  tried_a, 32'd0);

    // Reset in the middle of CHECK
    ct_len = 8'd200;
    good_key[0] = 24'd0;
    applyStimulus(0, 24'd0);
    n = 0;
    while (!pt_sel[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_check", {31'd0, pt_sel[0]}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_rdy_sel", {30'd0, rdy[0], pt_sel[0]}, 32'b10);
    checkOutput("midrst_key",     key_a, 32'd0);
    checkOutput("midrst_status",  {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'd0);
    checkOutput("midrst_tried",   tried_a, 32'd0);
    checkOutput("midrst_a4",      {7'd0, a4_en[0], a4key_a}, 32'd0);
    checkOutput("midrst_pt_addr", pt_addr_o[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = a4_cnt[0];
    repeat (5) @(negedge clk);
    checkOutput("midrst_no_kick", a4_cnt[0] - p0, 32'd0);
    ct_len = 8'd2;
    good_key[0] = 24'h000011;
    applyStimulus(0, 24'h000010);
    waitDone(0, 100, n);
    checkOutput("restart_key",    key_a, 32'h11);
    checkOutput("restart_status", {29'd0, key_valid[0], exhausted[0], aborted[0]}, 32'b100);
    checkOutput("restart_tried",  tried_a, 32'd2);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
